// File: rtl/fetch_mem_arbiter_if.sv
// Fetch/data request ports and memory command port of the shared-memory arbiter.
interface fetch_mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        halt;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_dump;
    logic        err;
    logic [1:0]  err_code;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata, mem_done,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, err, err_code
    );
    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, halt, mem_rdata, mem_done,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, err, err_code
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Sequences the single-ported multi-cycle memory between fetch and data requesters.
// Optional ARB_ROUND_ROBIN_EN: alternate priority on ties instead of fixed data-first.
module fetch_mem_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic               clk,
    input  logic               rst,
    fetch_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IF_WAIT, DM_WAIT, RESP, DUMP, HALTED} state_t;
    state_t state, nxt;

    logic [TW-1:0] tcnt;
    logic          pend;     // misaligned grant: RESP holds one extra cycle before the done pulse
    logic          gnt_dm;
    logic          wr_q;
    logic          if_done_q, dm_done_q, mem_en_q, mem_wr_q, mem_dump_q, err_q;
    logic [1:0]    err_code_q;
    logic [15:0]   if_rdata_q, dm_rdata_q, mem_addr_q, mem_wdata_q;

    logic          pick_dm, any_req, go_halt, tmo;
    logic [15:0]   sel_addr;
    logic [TW-1:0] tcnt_inc;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm;
    assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
`else
    assign pick_dm = bus.dm_req;
`endif
    assign any_req  = bus.dm_req | bus.if_req;
    assign go_halt  = bus.halt & ~bus.dm_req;
    assign sel_addr = pick_dm ? bus.dm_addr : bus.if_addr;
    assign tcnt_inc = tcnt + TW'(1);
    assign tmo      = (tcnt_inc == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (go_halt)      nxt = DUMP;
                else if (any_req) nxt = sel_addr[0] ? RESP : (pick_dm ? DM_WAIT : IF_WAIT);
            end
            IF_WAIT, DM_WAIT: if (bus.mem_done || tmo) nxt = RESP;
            RESP:             if (!pend) nxt = IDLE;
            DUMP:             nxt = HALTED;
            default:          nxt = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt        <= '0;
            pend        <= 1'b0;
            gnt_dm      <= 1'b0;
            wr_q        <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dump_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            if_rdata_q  <= 16'h0000;
            dm_rdata_q  <= 16'h0000;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
            last_dm     <= 1'b1;
`endif
        end else begin
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_dump_q <= 1'b0;
            case (state)
                IDLE: if (!go_halt && any_req) begin
                    gnt_dm <= pick_dm;
                    wr_q   <= pick_dm & bus.dm_wr;
                    tcnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dm <= pick_dm;
`endif
                    if (sel_addr[0]) begin
                        pend <= 1'b1;
                        if (pick_dm) dm_rdata_q <= 16'h0000;
                        else         if_rdata_q <= 16'h0000;
                        if (!err_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= pick_dm ? 2'b10 : 2'b01;
                        end
                    end else begin
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= pick_dm & bus.dm_wr;
                        mem_addr_q <= sel_addr;
                        if (pick_dm) mem_wdata_q <= bus.dm_wdata;
                    end
                end
                IF_WAIT, DM_WAIT: begin
                    tcnt <= tcnt_inc;
                    if (bus.mem_done || tmo) begin
                        if_done_q <= ~gnt_dm;
                        dm_done_q <= gnt_dm;
                        if (gnt_dm) dm_rdata_q <= (bus.mem_done && !wr_q) ? bus.mem_rdata : 16'h0000;
                        else        if_rdata_q <= bus.mem_done ? bus.mem_rdata : 16'h0000;
                        if (!bus.mem_done && !err_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b11;
                        end
                    end
                end
                RESP: if (pend) begin
                    pend      <= 1'b0;
                    if_done_q <= ~gnt_dm;
                    dm_done_q <= gnt_dm;
                end
                DUMP:    mem_dump_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_dump  = mem_dump_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: memory model with settable latency, response scoreboard.
module tb_fetch_mem_arbiter;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic        is_dm;
        logic [15:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    fetch_mem_arbiter_if bus();

    fetch_mem_arbiter #(.TIMEOUT(TIMEOUT), .TW(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    exp_t sb[$];
    exp_t mon_e;

    // memory model state
    logic [15:0] mem [logic [15:0]];
    int          lat = 3;
    int          mcnt = 0;
    logic        mbusy = 1'b0;
    logic [15:0] maddr = 16'h0000;
    int          n_en = 0;
    logic [15:0] last_wa = 16'h0000;
    logic [15:0] last_wd = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] mword(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hC3A5;
    endfunction

    // mem_done is raised lat negedges after the command is seen
    always @(negedge clk) begin
        bus.mem_done = 1'b0;
        if (mbusy) begin
            mcnt--;
            if (mcnt == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = mword(maddr);
                mbusy = 1'b0;
            end
        end
        if (bus.mem_en === 1'b1) begin
            n_en++;
            mbusy = 1'b1;
            mcnt  = lat;
            maddr = bus.mem_addr;
            if (bus.mem_wr === 1'b1) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                last_wa = bus.mem_addr;
                last_wd = bus.mem_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: if_done=%b dm_done=%b with nothing outstanding", bus.if_done, bus.dm_done);
            end else begin
                mon_e = sb.pop_front();
                if (bus.dm_done !== mon_e.is_dm || bus.if_done !== !mon_e.is_dm ||
                    (mon_e.is_dm ? bus.dm_rdata : bus.if_rdata) !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL sb_response: got dm=%b if=%b rdata=%h/%h, want dm=%b rdata=%h",
                             bus.dm_done, bus.if_done, bus.dm_rdata, bus.if_rdata, mon_e.is_dm, mon_e.rdata);
                end
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic issue(input logic is_dm, input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        @(negedge clk);
        t0 = cyc;
        if (is_dm) begin
            bus.dm_wr = wr; bus.dm_addr = addr; bus.dm_wdata = wd; bus.dm_req = 1'b1;
        end else begin
            bus.if_addr = addr; bus.if_req = 1'b1;
        end
    endtask

    task automatic wait_done(input logic is_dm, input int budget, output logic ok, output int rel);
        int n = 0;
        ok = 1'b0;
        rel = -1;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if ((is_dm ? bus.dm_done : bus.if_done) === 1'b1) begin
                ok  = 1'b1;
                rel = cyc - t0;
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.mem_en !== 1'b0 || bus.mem_wr !== 1'b0 ||
            bus.mem_dump !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: done=%b%b en=%b wr=%b dump=%b err=%b code=%b, want all 0",
                     bus.if_done, bus.dm_done, bus.mem_en, bus.mem_wr, bus.mem_dump, bus.err, bus.err_code);
        end
        checks++;
        if (bus.if_rdata !== 16'h0 || bus.dm_rdata !== 16'h0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h, want 0000",
                     bus.if_rdata, bus.dm_rdata, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_fetch;
        logic ok; int rel; int en0;
        lat = 3;
        en0 = n_en;
        sb.push_back('{1'b0, mword(16'h0010)});
        issue(1'b0, 1'b0, 16'h0010, 16'h0);
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cmd: en=%b addr=%h wr=%b, want en=1 addr=0010 wr=0", bus.mem_en, bus.mem_addr, bus.mem_wr);
        end
        checks++;
        if (bus.if_stall !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall: if_stall=%b, want 1", bus.if_stall);
        end
        wait_done(1'b0, 20, ok, rel);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || rel != 5) begin
            errors++;
            $display("FAIL fetch_latency: done seen=%b at cycle %0d, want cycle 5", ok, rel);
        end
        checks++;
        if (n_en - en0 != 1) begin
            errors++;
            $display("FAIL fetch_en_count: %0d commands, want 1", n_en - en0);
        end
    endtask

    task automatic test_tie;
        int d_dm, d_if, en1, en2, n, first;
        logic ok; int rel;
        d_dm = -1; d_if = -1; en1 = -1; en2 = -1; n = 0;
        lat = 2;
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{1'b0, mword(16'h0020)});
        sb.push_back('{1'b1, 16'h0000});
`else
        sb.push_back('{1'b1, 16'h0000});
        sb.push_back('{1'b0, mword(16'h0020)});
`endif
        @(negedge clk);
        t0 = cyc;
        bus.dm_wr = 1'b1; bus.dm_addr = 16'h0100; bus.dm_wdata = 16'hBEEF; bus.if_addr = 16'h0020;
        bus.dm_req = 1'b1; bus.if_req = 1'b1;
        while (n < 40 && (bus.dm_req || bus.if_req)) begin
            @(negedge clk);
            n++;
            if (bus.mem_en === 1'b1) begin
                if (en1 < 0) en1 = cyc - t0;
                else if (en2 < 0) en2 = cyc - t0;
            end
            if (bus.dm_done === 1'b1) begin d_dm = cyc - t0; bus.dm_req = 1'b0; end
            if (bus.if_done === 1'b1) begin d_if = cyc - t0; bus.if_req = 1'b0; end
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        checks++;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_dm < 0 || d_if < 0 || !(d_if < d_dm)) begin
`else
        if (d_dm < 0 || d_if < 0 || !(d_dm < d_if)) begin
`endif
            errors++;
            $display("FAIL tie_order: dm_done at %0d if_done at %0d, wrong grant order", d_dm, d_if);
        end
        first = (d_dm < d_if) ? d_dm : d_if;
        checks++;
        if (en1 != 1 || first != 4) begin
            errors++;
            $display("FAIL tie_first_timing: mem_en at %0d done at %0d, want 1 and 4", en1, first);
        end
        checks++;
        if (en2 != first + 2) begin
            errors++;
            $display("FAIL back_to_back: second mem_en at %0d, want %0d", en2, first + 2);
        end
        checks++;
        if (last_wa !== 16'h0100 || last_wd !== 16'hBEEF) begin
            errors++;
            $display("FAIL tie_write: memory saw %h<=%h, want 0100<=BEEF", last_wa, last_wd);
        end
        sb.push_back('{1'b1, 16'hBEEF});
        issue(1'b1, 1'b0, 16'h0100, 16'h0);
        wait_done(1'b1, 20, ok, rel);
        bus.dm_req = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL readback_done: no dm_done within budget, want done");
        end
    endtask

    task automatic test_misalign;
        logic ok; int rel; int en0;
        en0 = n_en;
        sb.push_back('{1'b1, 16'h0000});
        issue(1'b1, 1'b0, 16'h0003, 16'h0);
        wait_done(1'b1, 10, ok, rel);
        bus.dm_req = 1'b0;
        checks++;
        if (!ok || rel != 2) begin
            errors++;
            $display("FAIL misalign_latency: done seen=%b at cycle %0d, want cycle 2", ok, rel);
        end
        checks++;
        if (n_en != en0) begin
            errors++;
            $display("FAIL misalign_no_cmd: %0d commands issued, want 0", n_en - en0);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'b10) begin
            errors++;
            $display("FAIL misalign_err: err=%b code=%b, want 1/10", bus.err, bus.err_code);
        end
    endtask

    task automatic test_timeout;
        logic ok; int rel; int late;
        do_reset();
        lat = 80;
        sb.push_back('{1'b0, 16'h0000});
        issue(1'b0, 1'b0, 16'h0030, 16'h0);
        wait_done(1'b0, 100, ok, rel);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || rel != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_latency: done seen=%b at cycle %0d, want %0d", ok, rel, TIMEOUT + 1);
        end
        checks++;
        if (bus.err !== 1'b1 || bus.err_code !== 2'b11) begin
            errors++;
            $display("FAIL timeout_err: err=%b code=%b, want 1/11", bus.err, bus.err_code);
        end
        late = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL timeout_late_done: %0d done pulses after late mem_done, want 0", late);
        end
        sb.push_back('{1'b0, 16'h0000});
        issue(1'b0, 1'b0, 16'h0031, 16'h0);
        wait_done(1'b0, 10, ok, rel);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || bus.err_code !== 2'b11) begin
            errors++;
            $display("FAIL err_sticky: done=%b code=%b, want done and code 11 kept", ok, bus.err_code);
        end
    endtask

    task automatic test_halt;
        logic ok; int rel; int en0; int dumps;
        do_reset();
        lat = 3;
        sb.push_back('{1'b0, mword(16'h0040)});
        issue(1'b0, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        @(negedge clk);
        bus.halt = 1'b1;
        wait_done(1'b0, 20, ok, rel);
        checks++;
        if (!ok || rel != 5) begin
            errors++;
            $display("FAIL halt_fetch_completes: done seen=%b at cycle %0d, want cycle 5", ok, rel);
        end
        // if_req stays high: a new fetch that must never be served
        en0 = n_en;
        dumps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.mem_dump === 1'b1) dumps++;
        end
        checks++;
        if (dumps != 1) begin
            errors++;
            $display("FAIL halt_dump: %0d dump pulses, want 1", dumps);
        end
        checks++;
        if (n_en != en0 || bus.if_stall !== 1'b1) begin
            errors++;
            $display("FAIL halted_quiet: %0d commands, if_stall=%b, want 0 and 1", n_en - en0, bus.if_stall);
        end
    endtask

    task automatic test_rst_mid;
        logic ok; int rel; int stray;
        bus.if_req = 1'b0;
        bus.halt = 1'b0;
        do_reset();
        lat = 10;
        sb.push_back('{1'b1, mword(16'h0050)});
        issue(1'b1, 1'b0, 16'h0050, 16'h0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.mem_addr !== 16'h0 || bus.dm_done !== 1'b0 || bus.mem_en !== 1'b0 ||
            bus.err !== 1'b0 || bus.dm_rdata !== 16'h0 || bus.if_rdata !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: mem_addr=%h dm_done=%b en=%b err=%b rdata=%h/%h, want all 0",
                     bus.mem_addr, bus.dm_done, bus.mem_en, bus.err, bus.dm_rdata, bus.if_rdata);
        end
        sb.delete();
        bus.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_late_done: %0d done pulses after reset, want 0", stray);
        end
        lat = 3;
        sb.push_back('{1'b0, mword(16'h0060)});
        issue(1'b0, 1'b0, 16'h0060, 16'h0);
        wait_done(1'b0, 20, ok, rel);
        bus.if_req = 1'b0;
        checks++;
        if (!ok || rel != 5) begin
            errors++;
            $display("FAIL post_reset_fetch: done seen=%b at cycle %0d, want cycle 5", ok, rel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 16'h0; bus.dm_req = 1'b0; bus.dm_wr = 1'b0;
        bus.dm_addr = 16'h0; bus.dm_wdata = 16'h0; bus.halt = 1'b0;
        bus.mem_done = 1'b0; bus.mem_rdata = 16'h0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_fetch();
        test_tie();
        test_misalign();
        test_timeout();
        test_halt();
        test_rst_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_mem_arbiter.md
# fetch_mem_arbiter

Sequences the shared single-ported, multi-cycle memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). It owns the memory's command port. It also provides per-requester done/stall handshakes, misalignment and timeout errors, and the halt-time dump pulse. It sits between the fetch/memory stages and the memory model, and replaces their direct, always-enabled memory hookups.

## Interface
Parameters:
- `TIMEOUT`, default 64: max cycles to wait for `mem_done` before flagging an error.
- `TW`, default 7: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_done`.
- `if_addr` in 16: instruction address (PC).
- `if_rdata` out 16: fetched instruction. Valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse.
- `if_stall` out 1: `if_req` & !`if_done`.
- `dm_req` in 1: data request. `dm_wr`, `dm_addr`, `dm_wdata` are held until `dm_done`.
- `dm_wr` in 1: 1 = write, 0 = read.
- `dm_addr` in 16: data address.
- `dm_wdata` in 16: write data.
- `dm_rdata` out 16: read data. Valid while `dm_done`=1.
- `dm_done` out 1: one-cycle completion pulse.
- `dm_stall` out 1: `dm_req` & !`dm_done`.
- `halt` in 1: processor halt (level).
- `mem_en` out 1: one-cycle command strobe to memory.
- `mem_wr` out 1: write qualifier for `mem_en`.
- `mem_addr` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data. Valid with `mem_done`.
- `mem_done` in 1: memory completion. Arrives at least 1 cycle after `mem_en`.
- `mem_dump` out 1: one-cycle dump pulse (createdump).
- `err` out 1: sticky error flag.
- `err_code` out 2: 01 = misaligned fetch, 10 = misaligned data, 11 = timeout.

## Operation
- FSM states: IDLE, IF_WAIT, DM_WAIT, RESP, DUMP, HALTED.
- **IDLE, request selection:**
  - Priority is `dm_req` over `if_req` (see Configuration).
  - An address with bit 0 = 1 issues no memory command. Go to RESP with the done pulse asserted, rdata = 16'h0000, `err` set, and `err_code` loaded.
  - An aligned grant drives `mem_en`=1 for exactly one cycle with the latched addr/wr/wdata, then goes to IF_WAIT or DM_WAIT.
- **IF_WAIT/DM_WAIT:**
  - The timeout counter increments each cycle.
  - On `mem_done`: capture `mem_rdata` into the granted requester's rdata register, then go to RESP.
  - If the counter reaches `TIMEOUT` without `mem_done`: go to RESP with rdata = 16'h0000, `err`=1, `err_code`=11.
- **RESP:** pulse the granted `*_done` for one cycle, then return to IDLE. For writes, `dm_rdata` = 16'h0000.
- **Halt:**
  - When `halt`=1 in IDLE with no `dm_req` pending: go to DUMP, then pulse `mem_dump` for one cycle, then go to HALTED.
  - Halt is never honoured mid-transaction; the in-flight access completes first.
  - A pending `dm_req` is served before the dump.
- **HALTED:** absorbing. No further `mem_en`; `if_stall` stays asserted. Only reset exits.
- `err`/`err_code` are sticky until reset. When several errors occur, the first one wins.
- Only one memory transaction is outstanding at any time.

## Timing
- Reset values:
  - FSM = IDLE.
  - All `*_done`, `mem_en`, `mem_wr`, `mem_dump`, `err` = 0.
  - `err_code` = 00.
  - All data/address outputs = 16'h0000.
  - Timeout counter = 0.
- Reset asserted mid-transaction aborts immediately with no done pulse. A late `mem_done` arriving after reset is ignored in IDLE.
- All outputs are registered except `if_stall`/`dm_stall`, which are combinational.
- Read latency from request to done:
  - request seen in IDLE at cycle 0 → `mem_en` at cycle 1 → `mem_done` at cycle 1+L → done at cycle 2+L.
- Misaligned access: done at cycle 2.
- Back-to-back: the earliest next `mem_en` comes 2 cycles after the previous done. IDLE re-arbitrates at the cycle after RESP.
- A `mem_done` seen outside IF_WAIT/DM_WAIT is ignored.
- Simultaneous `if_req` and `dm_req` in IDLE: exactly one is granted. The other stalls and is served next.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - **Defined:** a 1-bit last-grant register alternates priority when both requests are pending. It resets to "last = data", so fetch wins the first tie.
  - **Undefined:** fixed data-over-fetch priority, with no last-grant register.

## Test plan
- Reset, then `if_req` with `if_addr`=16'h0010 and memory latency 3 → `mem_en` at cycle 1 with `mem_addr`=16'h0010. `if_done` at cycle 5 with `if_rdata` equal to the memory word.
- `if_req` and `dm_req` (write 16'hBEEF to 16'h0100) asserted together → data granted first. After `dm_done`, fetch is granted. With `ARB_ROUND_ROBIN_EN`, the first tie grants fetch instead.
- `dm_req` read at 16'h0003 → no `mem_en`, `dm_done` at cycle 2, `dm_rdata`=0, `err`=1, `err_code`=10.
- `mem_done` withheld for `TIMEOUT`=64 cycles → done pulse with rdata=0, `err_code`=11. A later `mem_done` is ignored.
- `halt` asserted during IF_WAIT → fetch completes, then exactly one `mem_dump` pulse. No further `mem_en`, even with `if_req` held high.
- `rst` driven low mid-DM_WAIT → outputs return to their reset values asynchronously. After `rst` is released, a new fetch completes normally.
